// File: rtl/array_scan_reader_if.sv
// Write-port, scan-control and output-stream bundle for array_scan_reader.
// master drives writes/start/out_ready; slave is the array_scan_reader side.
interface array_scan_reader_if #(
  parameter int unsigned W = 2,
  parameter int unsigned D = 7
);
  logic           wr_en;
  logic [W-1:0]   wr_addr;
  logic [D-1:0]   wr_data;
  logic           start;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_addr;
  logic [D-1:0]   out_data;
  logic           out_last;
  logic           done;
  logic [D+W-1:0] sum;

  modport master (
    output wr_en, wr_addr, wr_data, start, out_ready,
    input  busy, out_valid, out_addr, out_data, out_last, done, sum
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, out_ready,
    output busy, out_valid, out_addr, out_data, out_last, done, sum
  );
endinterface

// File: rtl/array_scan_reader.sv
// 2^W-entry register array with one write port and an in-order scan engine
// streaming every entry and reporting their sum. Optional ARRAY_SCAN_PARITY_EN.
module array_scan_reader #(
  parameter int unsigned W      = 2,
  parameter int unsigned D      = 7,
  parameter int          FINISH = 0
) (
  input  logic clock,
  input  logic reset_n,
  array_scan_reader_if.slave bus
`ifdef ARRAY_SCAN_PARITY_EN
  ,
  output logic parity_err
`endif
);

  localparam int unsigned N = 1 << W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    FIN
  } state_t;

  state_t         state;
  logic [D-1:0]   mem [N];
  logic [W-1:0]   ptr;
  logic [D+W-1:0] acc;
  logic [D+W-1:0] acc_next;

`ifdef ARRAY_SCAN_PARITY_EN
  logic           par_mem [N];
`endif

  // Non-blocking write against the FETCH read gives read-before-write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[i] <= '0;
`ifdef ARRAY_SCAN_PARITY_EN
        par_mem[i] <= 1'b0;
`endif
      end
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
`ifdef ARRAY_SCAN_PARITY_EN
      par_mem[bus.wr_addr] <= ^bus.wr_data;
`endif
    end
  end

  always_comb begin
    acc_next = acc + (D+W)'(bus.out_data);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      ptr           <= '0;
      acc           <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.done      <= 1'b0;
      bus.sum       <= '0;
`ifdef ARRAY_SCAN_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= FETCH;
            ptr      <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
`ifdef ARRAY_SCAN_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        FETCH: begin
          bus.out_data  <= mem[ptr];
          bus.out_addr  <= ptr;
          bus.out_last  <= (ptr == W'(N - 1));
          bus.out_valid <= 1'b1;
          state         <= PRESENT;
`ifdef ARRAY_SCAN_PARITY_EN
          if ((^mem[ptr]) != par_mem[ptr]) begin
            parity_err <= 1'b1;
          end
`endif
        end
        PRESENT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= acc_next;
            if (bus.out_last) begin
              // done and busy change together so FIN is visible as the done cycle.
              state    <= FIN;
              bus.sum  <= acc_next;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FETCH;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  if (FINISH != 0) begin : g_finish
    always_ff @(posedge clock) begin
      if (reset_n && bus.done) begin
        $display("array_scan_reader sum=%0d", bus.sum);
        $finish(FINISH);
      end
    end
  end
`endif

endmodule

// File: tb/tb_array_scan_reader.sv
// Self-checking bench for array_scan_reader: directed steps plus randomized
// scans checked against an array/queue-level model of the streamed contents.
module tb_array_scan_reader;
  localparam int W = 2;
  localparam int D = 7;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  array_scan_reader_if #(.W(W), .D(D)) bus ();

`ifdef ARRAY_SCAN_PARITY_EN
  logic parity_err;
`endif

  array_scan_reader #(.W(W), .D(D), .FINISH(0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef ARRAY_SCAN_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [D-1:0] model [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = W'(a);
    bus.wr_data = D'(d);
    step();
    bus.wr_en   = 1'b0;
    model[a]    = D'(d);
  endtask

  // stall: 0 = ready always, >0 = ready low that many cycles per entry, <0 = random.
  task automatic scan(input int stall, input bit rnd_wr, input bit mid_wr,
                      input bit keep_start, input bit started, input int exp_cycles);
    int cyc;
    int idx;
    int cnt;
    bit seen_done;
    bit fresh;
    bit first;
    logic rdy;
    logic [D-1:0] cur;
    logic [D+W-1:0] exp_sum;
    int a;
    exp_sum = '0;
    idx = 0;
    cnt = 0;
    seen_done = 1'b0;
    fresh = 1'b1;
    cur = '0;
    if (!started) begin
      bus.start = 1'b1;
      step();
      if (!keep_start) bus.start = 1'b0;
    end
    chk("busy_after_start", 64'(bus.busy), 64'(1));
    bus.out_ready = (stall == 0);
    for (cyc = 1; cyc < 300; cyc++) begin
      bus.wr_en = 1'b0;
      if (bus.done === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      chk("busy_during_scan", 64'(bus.busy), 64'(1));
      if (bus.out_valid === 1'b1) begin
        if (idx >= N) begin
          chk("extra_entry", 64'(idx), 64'(N - 1));
          break;
        end
        first = fresh;
        if (fresh) begin
          cur   = model[idx];
          fresh = 1'b0;
          cnt   = (stall < 0) ? 0 : stall;
        end
        chk("out_addr", 64'(bus.out_addr), 64'(idx));
        chk("out_data", 64'(bus.out_data), 64'(cur));
        chk("out_last", 64'(bus.out_last), 64'(idx == N - 1));
        if (stall < 0) rdy = 1'($urandom_range(1));
        else if (cnt > 0) begin
          rdy = 1'b0;
          cnt--;
        end else rdy = 1'b1;
        bus.out_ready = rdy;
        if (rdy) begin
          exp_sum = exp_sum + (D+W)'(cur);
          idx++;
          fresh = 1'b1;
        end
        if (mid_wr && first && bus.out_addr == 1) begin
          bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 7'd1; model[2] = 7'd1;
        end else if (mid_wr && first && bus.out_addr == 2) begin
          bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 7'd99; model[0] = 7'd99;
        end else if (rnd_wr && $urandom_range(2) == 0) begin
          a = int'($urandom_range(N - 1));
          bus.wr_en = 1'b1; bus.wr_addr = W'(a); bus.wr_data = D'($urandom);
          model[a] = bus.wr_data;
        end
      end else begin
        bus.out_ready = (stall == 0) ? 1'b1 : 1'b0;
      end
      step();
    end
    bus.wr_en = 1'b0;
    chk("done_seen", 64'(seen_done), 64'(1));
    if (exp_cycles > 0) chk("done_cycle", 64'(cyc), 64'(exp_cycles));
    chk("entries", 64'(idx), 64'(N));
    chk("sum", 64'(bus.sum), 64'(exp_sum));
    chk("busy_at_done", 64'(bus.busy), 64'(0));
    step();
    chk("done_one_cycle", 64'(bus.done), 64'(0));
    chk("sum_held", 64'(bus.sum), 64'(exp_sum));
    chk("idle_busy", 64'(bus.busy), 64'(0));
    if (keep_start) begin
      step();
      chk("restart_busy", 64'(bus.busy), 64'(1));
      bus.start = 1'b0;
    end
  endtask

  initial begin
    bit any_done;
    int i;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < N; k++) model[k] = '0;

    // Dirty the array before reset so the clear is observable.
    reset_n = 1'b1;
    step();
    write(1, 33);
    write(3, 77);
    reset_n = 1'b0;
    step();
    step();
    for (int k = 0; k < N; k++) model[k] = '0;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_last", 64'(bus.out_last), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_addr", 64'(bus.out_addr), 64'(0));
    chk("rst_data", 64'(bus.out_data), 64'(0));
    chk("rst_sum", 64'(bus.sum), 64'(0));
    reset_n = 1'b1;
    step();

    scan(0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    chk("zero_sum", 64'(bus.sum), 64'(0));

    write(0, 5);
    write(1, 10);
    write(2, 15);
    write(3, 127);
    scan(0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    chk("sum_157", 64'(bus.sum), 64'(157));

    scan(3, 1'b0, 1'b0, 1'b0, 1'b0, 9 + 4 * 3);
    chk("stall_sum_157", 64'(bus.sum), 64'(157));

    scan(0, 1'b0, 1'b1, 1'b0, 1'b0, 9);
    chk("mid_write_sum_143", 64'(bus.sum), 64'(143));

    scan(0, 1'b0, 1'b0, 1'b1, 1'b0, 9);
    scan(0, 1'b0, 1'b0, 1'b0, 1'b1, 9);

    // Reset while address 1 is being presented.
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (i = 0; i < 20 && !(bus.out_valid === 1'b1 && bus.out_addr == 1); i++) step();
    chk("reached_addr1", 64'(bus.out_valid === 1'b1 && bus.out_addr == 1), 64'(1));
    reset_n = 1'b0;
    step();
    for (int k = 0; k < N; k++) model[k] = '0;
    chk("abort_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    reset_n = 1'b1;
    any_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) any_done = 1'b1;
    end
    chk("no_done_after_abort", 64'(any_done), 64'(0));
    scan(0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    chk("post_abort_sum", 64'(bus.sum), 64'(0));

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) write(k, int'($urandom_range(127)));
      scan(-1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    end

`ifdef ARRAY_SCAN_PARITY_EN
    write(3, 3);
    chk("par_clean", 64'(parity_err), 64'(0));
    dut.par_mem[3] = ~dut.par_mem[3];
    scan(0, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    chk("par_err_set", 64'(parity_err), 64'(1));
    step();
    chk("par_err_sticky", 64'(parity_err), 64'(1));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("par_err_cleared", 64'(parity_err), 64'(0));
    scan(0, 1'b0, 1'b0, 1'b0, 1'b1, 9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
